psw_unit: RTL and testbench

PSW_UNIT -- requirements
Module: psw_unit

---
 rtl/psw_unit.sv | 171 +++++++++++++++++
 tb/tb_psw_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psw_unit.sv
// psw_unit: processor status word register with flag update paths
// (ALU merge, SETCC/CLRCC) and a 4-deep shadow stack used to save and
// restore the PSW across exception entry and return.
module psw_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [15:0] alu_psw,
    input  logic [15:0] alu_msk,
    input  logic        cc_valid,
    input  logic        cc_set,
    input  logic [4:0]  cc_bits,
    input  logic        exc_entry,
    input  logic [2:0]  exc_pri,
    input  logic        exc_return,
    output logic [15:0] psw,
    output logic        carry_in,
    output logic        busy,
    output logic [2:0]  depth,
    output logic        stack_ovf,
    output logic        stack_unf
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PUSH   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_POP    = 2'd3
    } state_t;

    // Merge new flag values into the current flags under a per-bit mask.
    function automatic logic [4:0] f_merge_flags(input logic [4:0] cur,
                                                 input logic [4:0] val,
                                                 input logic [4:0] msk);
        return (cur & ~msk) | (val & msk);
    endfunction

    // Force the reserved field to zero whatever the write source is.
    function automatic logic [15:0] f_clean_psw(input logic [15:0] p);
        return {p[15:13], 4'b0000, p[8:0]};
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_psw;
    logic [15:0] w_psw_next;
    logic [2:0]  r_depth;
    logic [2:0]  w_depth_next;
    logic [2:0]  r_pri;
    logic [2:0]  w_pri_next;
    logic        r_full;
    logic        w_full_next;
    logic        r_ovf;
    logic        w_ovf_next;
    logic        r_unf;
    logic        w_unf_next;
    logic        r_busy;
    logic        w_push_we;
    logic [1:0]  w_push_idx;
    logic [1:0]  w_pop_idx;
    logic [15:0] r_stack [0:3];
    logic        w_unused;

    // Only the flag bits of the ALU value and mask take part in the update.
    assign w_unused   = ^{alu_psw[15:5], alu_msk[15:5]};
    assign w_push_idx = r_depth[1:0];
    assign w_pop_idx  = r_depth[1:0] - 2'd1;

    // Next-state and next-value logic for the PSW controller.
    always_comb begin
        w_next_state = r_state;
        w_psw_next   = r_psw;
        w_depth_next = r_depth;
        w_pri_next   = r_pri;
        w_full_next  = r_full;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_push_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (exc_entry) begin
                    // Priority is captured now; the requester may drop it.
                    w_next_state = ST_PUSH;
                    w_pri_next   = exc_pri;
                end else if (exc_return) begin
                    w_next_state = ST_POP;
                end else if (cc_valid) begin
                    if (cc_set) begin
                        w_psw_next = {r_psw[15:5], r_psw[4:0] | cc_bits};
                    end else begin
                        w_psw_next = {r_psw[15:5], r_psw[4:0] & ~cc_bits};
                    end
                end else if (alu_valid) begin
                    w_psw_next = {r_psw[15:5],
                                  f_merge_flags(r_psw[4:0], alu_psw[4:0], alu_msk[4:0])};
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (r_depth[2]) begin
                    // Stack already holds four entries: flag it, keep contents.
                    w_ovf_next  = 1'b1;
                    w_full_next = 1'b1;
                end else begin
                    w_push_we    = 1'b1;
                    w_depth_next = r_depth + 3'd1;
                    w_full_next  = 1'b0;
                end
                w_next_state = ST_UPDATE;
            end
            ST_UPDATE: begin
                // Old current priority becomes previous priority; flags clear.
                w_psw_next   = f_clean_psw({r_psw[7:5], 4'b0000, r_psw[8] | r_full,
                                            r_pri, 5'b00000});
                w_full_next  = 1'b0;
                w_next_state = ST_IDLE;
            end
            ST_POP: begin
                if (r_depth == 3'd0) begin
                    w_unf_next = 1'b1;
                end else begin
                    w_psw_next   = f_clean_psw(r_stack[w_pop_idx]);
                    w_depth_next = r_depth - 3'd1;
                end
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Controller registers; async reset discards any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_psw   <= 16'h0000;
            r_depth <= 3'd0;
            r_pri   <= 3'd0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_psw   <= f_clean_psw(w_psw_next);
            r_depth <= w_depth_next;
            r_pri   <= w_pri_next;
            r_full  <= w_full_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    // Shadow stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push_we) begin
            r_stack[w_push_idx] <= r_psw;
        end
    end

    assign psw       = r_psw;
    assign carry_in  = r_psw[0];
    assign busy      = r_busy;
    assign depth     = r_depth;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule

// File: tb/tb_psw_unit.sv
// Scoreboard bench for psw_unit: stimulus pushes hand-computed expectations
// tagged with the clock cycle they apply to; a monitor on the falling edge
// pops and compares them.
module tb_psw_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [15:0] alu_psw = 16'h0000;
    logic [15:0] alu_msk = 16'h0000;
    logic        cc_valid = 1'b0;
    logic        cc_set = 1'b0;
    logic [4:0]  cc_bits = 5'd0;
    logic        exc_entry = 1'b0;
    logic [2:0]  exc_pri = 3'd0;
    logic        exc_return = 1'b0;
    logic [15:0] psw;
    logic        carry_in;
    logic        busy;
    logic [2:0]  depth;
    logic        stack_ovf;
    logic        stack_unf;

    psw_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_psw(alu_psw), .alu_msk(alu_msk),
        .cc_valid(cc_valid), .cc_set(cc_set), .cc_bits(cc_bits),
        .exc_entry(exc_entry), .exc_pri(exc_pri), .exc_return(exc_return),
        .psw(psw), .carry_in(carry_in), .busy(busy), .depth(depth),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] p;
        logic [2:0]  d;
        logic        b;
        logic        ov;
        logic        un;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] ex);
        n_checks++;
        if (act !== ex) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    task automatic chk_all(input string nm, input logic [15:0] p, input logic [2:0] d,
                           input logic b, input logic ov, input logic un);
        chk({nm, ".psw"}, psw, p);
        chk({nm, ".carry"}, {15'd0, carry_in}, {15'd0, p[0]});
        chk({nm, ".depth"}, {13'd0, depth}, {13'd0, d});
        chk({nm, ".busy"}, {15'd0, busy}, {15'd0, b});
        chk({nm, ".ovf"}, {15'd0, stack_ovf}, {15'd0, ov});
        chk({nm, ".unf"}, {15'd0, stack_unf}, {15'd0, un});
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: check missed, due cycle %0d now %0d", e.nm, e.cyc, cyc);
            end else begin
                chk_all(e.nm, e.p, e.d, e.b, e.ov, e.un);
            end
        end
    end

    task automatic exp_at(input int c, input logic [15:0] p, input logic [2:0] d,
                          input logic b, input logic ov, input logic un, input string nm);
        exp_t e;
        e.cyc = c; e.p = p; e.d = d; e.b = b; e.ov = ov; e.un = un; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic clr();
        alu_valid = 1'b0; alu_psw = 16'h0000; alu_msk = 16'h0000;
        cc_valid = 1'b0; cc_set = 1'b0; cc_bits = 5'd0;
        exc_entry = 1'b0; exc_pri = 3'd0; exc_return = 1'b0;
    endtask

    // Single-cycle ALU or CC update; result visible after the accept edge.
    task automatic alu_op(input logic [15:0] ap, input logic [15:0] am, input logic [15:0] p_new,
                          input logic [2:0] d, input logic ov, input logic un, input string nm);
        int k;
        @(negedge clk);
        k = cyc + 1;
        alu_valid = 1'b1; alu_psw = ap; alu_msk = am;
        exp_at(k, p_new, d, 1'b0, ov, un, nm);
        @(negedge clk);
        clr();
    endtask

    task automatic cc_op(input logic s, input logic [4:0] bits, input logic [15:0] p_new,
                         input logic [2:0] d, input logic ov, input logic un, input string nm);
        int k;
        @(negedge clk);
        k = cyc + 1;
        cc_valid = 1'b1; cc_set = s; cc_bits = bits;
        exp_at(k, p_new, d, 1'b0, ov, un, nm);
        @(negedge clk);
        clr();
    endtask

    task automatic entry_op(input logic [2:0] pri, input logic [15:0] p_old, input logic [15:0] p_new,
                            input logic [2:0] d_old, input logic [2:0] d_new,
                            input logic ov_old, input logic ov_new, input logic un, input string nm);
        int k;
        @(negedge clk);
        k = cyc + 1;
        exc_entry = 1'b1; exc_pri = pri;
        exp_at(k,     p_old, d_old, 1'b1, ov_old, un, {nm, "@push"});
        exp_at(k + 1, p_old, d_new, 1'b1, ov_new, un, {nm, "@upd"});
        exp_at(k + 2, p_new, d_new, 1'b0, ov_new, un, nm);
        @(negedge clk);
        clr();
        @(negedge clk);
    endtask

    task automatic ret_op(input logic [15:0] p_old, input logic [15:0] p_new,
                          input logic [2:0] d_old, input logic [2:0] d_new,
                          input logic ov, input logic un_old, input logic un_new, input string nm);
        int k;
        @(negedge clk);
        k = cyc + 1;
        exc_return = 1'b1;
        exp_at(k,     p_old, d_old, 1'b1, ov, un_old, {nm, "@pop"});
        exp_at(k + 1, p_new, d_new, 1'b0, ov, un_new, nm);
        @(negedge clk);
        clr();
        @(negedge clk);
    endtask

    initial begin
        int k;
        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        exp_at(cyc + 1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "reset");
        @(negedge clk);
        rst = 1'b0;

        // ALU masked merge, then upper mask bits must be ignored.
        alu_op(16'h001F, 16'h0005, 16'h0005, 3'd0, 1'b0, 1'b0, "alu_merge");
        alu_op(16'hFFFF, 16'hFFE0, 16'h0005, 3'd0, 1'b0, 1'b0, "alu_hi_mask");
        alu_op(16'h0013, 16'h001F, 16'h0013, 3'd0, 1'b0, 1'b0, "alu_full");
        // SETCC then CLRCC.
        cc_op(1'b1, 5'b01000, 16'h001B, 3'd0, 1'b0, 1'b0, "setcc");
        cc_op(1'b0, 5'b10001, 16'h000A, 3'd0, 1'b0, 1'b0, "clrcc");

        // Build psw=00A3, then entry pri 6 and return.
        entry_op(3'd5, 16'h000A, 16'h00A0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "entry_p5");
        alu_op(16'h0003, 16'h001F, 16'h00A3, 3'd1, 1'b0, 1'b0, "alu_flags");
        entry_op(3'd6, 16'h00A3, 16'hA0C0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, "entry_p6");
        ret_op(16'hA0C0, 16'h00A3, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, "ret_a3");
        ret_op(16'h00A3, 16'h000A, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, "ret_0a");

        // Five entries: the fifth overflows and sets FLT.
        entry_op(3'd1, 16'h000A, 16'h0020, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "e1");
        entry_op(3'd2, 16'h0020, 16'h2040, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, "e2");
        entry_op(3'd3, 16'h2040, 16'h4060, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, "e3");
        entry_op(3'd4, 16'h4060, 16'h6080, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, "e4");
        entry_op(3'd5, 16'h6080, 16'h81A0, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, "e5_ovf");
        // Five returns: the fourth restores the first PSW, the fifth underflows.
        ret_op(16'h81A0, 16'h4060, 3'd4, 3'd3, 1'b1, 1'b0, 1'b0, "r1");
        ret_op(16'h4060, 16'h2040, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, "r2");
        ret_op(16'h2040, 16'h0020, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, "r3");
        ret_op(16'h0020, 16'h000A, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, "r4");
        ret_op(16'h000A, 16'h000A, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, "r5_unf");

        // All requests at once: only entry; ALU held during busy is ignored.
        @(negedge clk);
        k = cyc + 1;
        exc_entry = 1'b1; exc_pri = 3'd3; exc_return = 1'b1;
        cc_valid = 1'b1; cc_set = 1'b1; cc_bits = 5'b11111;
        alu_valid = 1'b1; alu_psw = 16'h001F; alu_msk = 16'h001F;
        exp_at(k,     16'h000A, 3'd0, 1'b1, 1'b1, 1'b1, "prio@push");
        exp_at(k + 1, 16'h000A, 3'd1, 1'b1, 1'b1, 1'b1, "prio@upd");
        exp_at(k + 2, 16'h0060, 3'd1, 1'b0, 1'b1, 1'b1, "prio_entry");
        exp_at(k + 3, 16'h0060, 3'd1, 1'b0, 1'b1, 1'b1, "busy_ignored");
        @(negedge clk);
        clr();
        alu_valid = 1'b1; alu_psw = 16'h001F; alu_msk = 16'h001F;
        @(negedge clk);
        @(negedge clk);
        clr();
        @(negedge clk);

        // Return beats CC and ALU.
        @(negedge clk);
        k = cyc + 1;
        exc_return = 1'b1;
        cc_valid = 1'b1; cc_set = 1'b1; cc_bits = 5'b11111;
        alu_valid = 1'b1; alu_psw = 16'h001F; alu_msk = 16'h001F;
        exp_at(k,     16'h0060, 3'd1, 1'b1, 1'b1, 1'b1, "prio_ret@pop");
        exp_at(k + 1, 16'h000A, 3'd0, 1'b0, 1'b1, 1'b1, "prio_ret");
        @(negedge clk);
        clr();
        @(negedge clk);

        // Reset asserted during UPDATE clears everything immediately.
        @(negedge clk);
        k = cyc + 1;
        exc_entry = 1'b1; exc_pri = 3'd7;
        exp_at(k,     16'h000A, 3'd0, 1'b1, 1'b1, 1'b1, "rst_case@push");
        exp_at(k + 1, 16'h000A, 3'd1, 1'b1, 1'b1, 1'b1, "rst_case@upd");
        @(negedge clk);
        clr();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all("rst_async", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        exp_at(k + 2, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "rst_hold");
        @(negedge clk);
        rst = 1'b0;
        alu_valid = 1'b1; alu_psw = 16'h001F; alu_msk = 16'h001F;
        exp_at(k + 3, 16'h001F, 3'd0, 1'b0, 1'b0, 1'b0, "first_after_rst");
        @(negedge clk);
        clr();

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
